// File: rtl/dmem_lsu.sv
// Load/store unit: turns a core access into a word-aligned memory request
// and runs a valid/ack handshake with a variable-latency data memory.
module dmem_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic [31:0] resp_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [CW-1:0] r_cnt;
  logic        r_req;
  logic        r_bus_err;
  logic [31:0] r_addr;
  logic [3:0]  r_we;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic        w_byte;
  logic        w_half;
  logic        w_word;
  logic        w_go;
  logic        w_tmo;
  logic        w_stall;
  logic [3:0]  w_we;
  logic [31:0] w_wdata;
  logic        w_unused;

  // The unsigned flag only matters to the load formatter downstream.
  assign w_unused = req_size[2];

  assign w_byte = (req_size[1:0] == 2'b00);
  assign w_half = (req_size[1:0] == 2'b01);
  assign w_word = req_size[1];

  assign misalign = req_valid &
                    ((w_half & req_addr[0]) |
                     (w_word & (req_addr[1:0] != 2'b00)));
  assign w_go = req_valid & ~misalign;

  always_comb begin
    w_we    = 4'b0000;
    w_wdata = 32'h0;
    if (req_we) begin
      unique case (1'b1)
        w_byte: begin
          w_we    = 4'b0001 << req_addr[1:0];
          w_wdata = {4{req_wdata[7:0]}};
        end
        w_half: begin
          w_we    = req_addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{req_wdata[15:0]}};
        end
        w_word: begin
          w_we    = 4'b1111;
          w_wdata = req_wdata;
        end
      endcase
    end
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_tmo   = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));
    unique case (r_state)
      S_IDLE: begin
        w_stall = w_go;
        if (w_go) w_next = S_BUSY;
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (mem_ack || w_tmo) w_next = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req     <= 1'b0;
      r_bus_err <= 1'b0;
      r_addr    <= 32'h0;
      r_we      <= 4'b0000;
      r_wdata   <= 32'h0;
      r_rdata   <= 32'h0;
      r_cnt     <= '0;
    end else begin
      r_bus_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_addr  <= {req_addr[31:2], 2'b00};
            r_we    <= w_we;
            r_wdata <= w_wdata;
            r_req   <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_BUSY: begin
          // A load is the only access with no byte enables set.
          if (mem_ack) begin
            r_req <= 1'b0;
            if (r_we == 4'b0000) r_rdata <= mem_rdata;
          end else if (w_tmo) begin
            r_req     <= 1'b0;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign stall      = w_stall & ~reset;
  assign bus_err    = r_bus_err;
  assign resp_rdata = r_rdata;
  assign mem_req    = r_req;
  assign mem_addr   = r_addr;
  assign mem_we     = r_we;
  assign mem_wdata  = r_wdata;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: a transaction-level model sets the
// expected outputs each cycle and a negedge process compares them.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        misalign;
  logic        bus_err;
  logic [31:0] resp_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  localparam int TMO = 16;

  dmem_lsu #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .misalign   (misalign),
    .bus_err    (bus_err),
    .resp_rdata (resp_rdata),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_stall = 0;
  int n_req = 0;
  int n_berr = 0;

  logic        chk_en = 1'b0;
  logic        exp_stall, exp_mis, exp_req, exp_berr;
  logic [31:0] exp_addr, exp_wd, m_rdata;
  logic [3:0]  exp_we;
  logic [31:0] cap_addr, cap_wd;
  logic [3:0]  cap_we;

  function automatic void chk(input string nm, input logic [31:0] a,
                              input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
    end
  endfunction

  function automatic int nbytes(input logic [2:0] sz);
    return sz[1] ? 4 : (sz[0] ? 2 : 1);
  endfunction

  function automatic logic m_mis(input logic [2:0] sz, input logic [31:0] a);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] m_we(input logic we, input logic [2:0] sz,
                                      input logic [31:0] a);
    int n;
    if (!we) return 4'b0000;
    n = nbytes(sz);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wd(input logic we, input logic [2:0] sz,
                                       input logic [31:0] wd);
    int n;
    logic [63:0] mask;
    logic [31:0] r;
    if (!we) return 32'h0;
    n = nbytes(sz);
    mask = (64'd1 << (8 * n)) - 64'd1;
    r = 32'h0;
    for (int i = 0; i < 4; i += n)
      r |= 32'((64'(wd) & mask) << (8 * i));
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("misalign", 32'(misalign), 32'(exp_mis));
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      chk("bus_err", 32'(bus_err), 32'(exp_berr));
      chk("resp_rdata", resp_rdata, m_rdata);
      if (exp_req) begin
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        chk("mem_wdata", mem_wdata, exp_wd);
      end
      if (stall) n_stall++;
      if (mem_req) n_req++;
      if (bus_err) n_berr++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ack_n: BUSY cycle carrying mem_ack (0 = never acked)
  task automatic access(input logic we, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int ack_n, input logic [31:0] rd);
    logic tmo;
    int   k;
    req_valid = 1'b1;
    req_we    = we;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
    mem_ack   = 1'b0;
    exp_mis   = m_mis(sz, a);
    exp_stall = !exp_mis;
    exp_req   = 1'b0;
    exp_berr  = 1'b0;
    n_stall   = 0;
    n_req     = 0;
    n_berr    = 0;
    tick();
    if (exp_mis) begin
      req_valid = 1'b0;
      exp_mis   = 1'b0;
      exp_stall = 1'b0;
      return;
    end
    exp_req   = 1'b1;
    exp_stall = 1'b1;
    exp_addr  = a & ~32'h3;
    exp_we    = m_we(we, sz, a);
    exp_wd    = m_wd(we, sz, wd);
    cap_addr  = mem_addr;
    cap_we    = mem_we;
    cap_wd    = mem_wdata;
    tmo = 1'b1;
    k   = 1;
    while (k <= TMO) begin
      mem_ack   = (k == ack_n);
      mem_rdata = (k == ack_n) ? rd : (32'hBAD0_0000 | 32'(k));
      tick();
      if (k == ack_n) begin
        tmo = 1'b0;
        break;
      end
      k++;
    end
    mem_ack   = 1'b0;
    exp_req   = 1'b0;
    exp_stall = 1'b0;
    exp_berr  = tmo;
    if (!we && !tmo) m_rdata = rd;
    tick();
    req_valid = 1'b0;
    exp_berr  = 1'b0;
    exp_mis   = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = 3'b010;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    exp_stall = 1'b0;
    exp_mis   = 1'b0;
    exp_req   = 1'b0;
    exp_berr  = 1'b0;
    exp_addr  = 32'h0;
    exp_we    = 4'h0;
    exp_wd    = 32'h0;
    m_rdata   = 32'h0;
    chk_en    = 1'b1;
    idle(2);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    reset = 1'b0;
    idle(1);

    // SB 0x1003, ack on first BUSY cycle
    access(1'b1, 3'b000, 32'h0000_1003, 32'h1234_56AB, 1, 32'h0);
    chk("sb_addr", cap_addr, 32'h0000_1000);
    chk("sb_we", 32'(cap_we), 32'h8);
    chk("sb_wdata", cap_wd, 32'hABAB_ABAB);
    chk("sb_stall_cycles", 32'(n_stall), 32'd2);
    idle(1);

    access(1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 2, 32'h0);
    chk("sh_we", 32'(cap_we), 32'hC);
    chk("sh_wdata", cap_wd, 32'hBEEF_BEEF);
    access(1'b1, 3'b010, 32'h0000_2004, 32'hCAFE_F00D, 1, 32'h0);
    chk("sw_we", 32'(cap_we), 32'hF);

    // LW with ack on the third BUSY cycle
    access(1'b0, 3'b010, 32'h0000_3000, 32'h0, 3, 32'hDEAD_BEEF);
    chk("lw_stall_cycles", 32'(n_stall), 32'd4);
    chk("lw_we", 32'(cap_we), 32'h0);
    chk("lw_rdata", resp_rdata, 32'hDEAD_BEEF);
    access(1'b1, 3'b001, 32'h0000_3000, 32'h0000_5555, 1, 32'h0);
    chk("st_keeps_rdata", resp_rdata, 32'hDEAD_BEEF);
    idle(1);

    // misaligned half/word, aligned byte
    access(1'b0, 3'b001, 32'h0000_4001, 32'h0, 1, 32'h1111_1111);
    chk("lh_mis_noreq", 32'(n_req), 32'd0);
    access(1'b0, 3'b010, 32'h0000_4002, 32'h0, 1, 32'h2222_2222);
    chk("lw_mis_noreq", 32'(n_req), 32'd0);
    idle(1);
    access(1'b0, 3'b100, 32'h0000_4001, 32'h0, 1, 32'h0000_00C3);
    chk("lbu_rdata", resp_rdata, 32'h0000_00C3);

    // no ack: timeout abort
    access(1'b0, 3'b010, 32'h0000_6000, 32'h0, 0, 32'h0);
    chk("tmo_req_cycles", 32'(n_req), 32'd16);
    chk("tmo_stall_cycles", 32'(n_stall), 32'd17);
    chk("tmo_berr_pulses", 32'(n_berr), 32'd1);
    chk("tmo_rdata", resp_rdata, 32'h0000_00C3);
    idle(2);

    // reset in BUSY cycle 2 with the request still presented
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 3'b010;
    req_addr  = 32'h0000_5000;
    exp_stall = 1'b1;
    tick();
    exp_req   = 1'b1;
    exp_addr  = 32'h0000_5000;
    exp_we    = 4'h0;
    exp_wd    = 32'h0;
    tick();
    reset     = 1'b1;
    exp_req   = 1'b0;
    exp_stall = 1'b0;
    m_rdata   = 32'h0;
    #1;
    chk("rstbusy_req", 32'(mem_req), 32'd0);
    chk("rstbusy_stall", 32'(stall), 32'd0);
    chk("rstbusy_rdata", resp_rdata, 32'h0);
    tick();
    reset     = 1'b0;
    req_valid = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    idle(3);
    chk("late_ack_req", 32'(mem_req), 32'd0);
    chk("late_ack_rdata", resp_rdata, 32'h0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
